// File: rtl/wb_arbiter.sv
// Round-robin arbiter that merges NUM_REQ result pipelines onto the single ROB
// writeback port through one registered output stage with backpressure and flush.
module wb_arbiter #(
  parameter int unsigned WORD_SIZE       = 32,
  parameter int unsigned ROB_ENTRY_WIDTH = 3,
  parameter int unsigned NUM_REQ         = 3,
  parameter int unsigned CNT_WIDTH       = 16,
  localparam int unsigned SRC_W          = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*ROB_ENTRY_WIDTH-1:0] req_rob_id,
  input  logic [NUM_REQ*WORD_SIZE-1:0]   req_result,
  input  logic [NUM_REQ*WORD_SIZE-1:0]   req_pc,
  input  logic [NUM_REQ-1:0]             req_exception,
  input  logic [NUM_REQ*WORD_SIZE-1:0]   req_vaddr_exc,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           rob_ready,
  output logic                           wb_valid,
  output logic [ROB_ENTRY_WIDTH-1:0]     wb_rob_id,
  output logic [WORD_SIZE-1:0]           wb_result,
  output logic [WORD_SIZE-1:0]           wb_pc,
  output logic                           wb_exception,
  output logic [WORD_SIZE-1:0]           wb_vaddr_exc,
  output logic [SRC_W-1:0]               wb_src,
  output logic [CNT_WIDTH-1:0]           conflict_cnt
);

  logic                       wb_valid_q, wb_valid_d;
  logic [ROB_ENTRY_WIDTH-1:0] wb_rob_id_q, wb_rob_id_d;
  logic [WORD_SIZE-1:0]       wb_result_q, wb_result_d;
  logic [WORD_SIZE-1:0]       wb_pc_q, wb_pc_d;
  logic                       wb_exception_q, wb_exception_d;
  logic [WORD_SIZE-1:0]       wb_vaddr_exc_q, wb_vaddr_exc_d;
  logic [SRC_W-1:0]           wb_src_q, wb_src_d;
  logic [SRC_W-1:0]           rr_ptr_q, rr_ptr_d;
  logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;

  logic                       load_en;
  logic                       found;
  logic                       grant;
  logic [SRC_W-1:0]           win_idx;
  logic [SRC_W-1:0]           sel;
  int unsigned                idx;

  assign load_en = ~flush & (~wb_valid_q | rob_ready);

  // Scan from rr_ptr upward with wrap; the first valid requester wins.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    idx     = 0;
    sel     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = k + 32'(rr_ptr_q);
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = SRC_W'(idx);
      if (!found && req_valid[sel]) begin
        found   = 1'b1;
        win_idx = sel;
      end
    end
  end

  // Reset gates the grant combinationally so no handshake is seen while held in reset.
  assign grant     = found & load_en & reset;
  assign req_ready = grant ? (NUM_REQ'(1) << win_idx) : '0;

  always_comb begin
    wb_valid_d     = wb_valid_q;
    wb_rob_id_d    = wb_rob_id_q;
    wb_result_d    = wb_result_q;
    wb_pc_d        = wb_pc_q;
    wb_exception_d = wb_exception_q;
    wb_vaddr_exc_d = wb_vaddr_exc_q;
    wb_src_d       = wb_src_q;
    rr_ptr_d       = rr_ptr_q;
    cnt_d          = cnt_q;

    if (flush) begin
      wb_valid_d = 1'b0;
    end else if (load_en) begin
      wb_valid_d = grant;
      if (grant) begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          if (SRC_W'(i) == win_idx) begin
            wb_rob_id_d    = req_rob_id[i*ROB_ENTRY_WIDTH +: ROB_ENTRY_WIDTH];
            wb_result_d    = req_result[i*WORD_SIZE +: WORD_SIZE];
            wb_pc_d        = req_pc[i*WORD_SIZE +: WORD_SIZE];
            wb_exception_d = req_exception[i];
            wb_vaddr_exc_d = req_vaddr_exc[i*WORD_SIZE +: WORD_SIZE];
          end
        end
        wb_src_d = win_idx;
        rr_ptr_d = (win_idx == SRC_W'(NUM_REQ - 1)) ? '0 : win_idx + SRC_W'(1);
      end
    end

    if (!flush && |(req_valid & ~req_ready) && cnt_q != '1) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid_q     <= 1'b0;
      wb_rob_id_q    <= '0;
      wb_result_q    <= '0;
      wb_pc_q        <= '0;
      wb_exception_q <= 1'b0;
      wb_vaddr_exc_q <= '0;
      wb_src_q       <= '0;
      rr_ptr_q       <= '0;
      cnt_q          <= '0;
    end else begin
      wb_valid_q     <= wb_valid_d;
      wb_rob_id_q    <= wb_rob_id_d;
      wb_result_q    <= wb_result_d;
      wb_pc_q        <= wb_pc_d;
      wb_exception_q <= wb_exception_d;
      wb_vaddr_exc_q <= wb_vaddr_exc_d;
      wb_src_q       <= wb_src_d;
      rr_ptr_q       <= rr_ptr_d;
      cnt_q          <= cnt_d;
    end
  end

  assign wb_valid     = wb_valid_q;
  assign wb_rob_id    = wb_rob_id_q;
  assign wb_result    = wb_result_q;
  assign wb_pc        = wb_pc_q;
  assign wb_exception = wb_exception_q;
  assign wb_vaddr_exc = wb_vaddr_exc_q;
  assign wb_src       = wb_src_q;
  assign conflict_cnt = cnt_q;

endmodule
